// File: rtl/distance_filter_bcd_pkg.sv
// Shared types and constants for the distance filter and its BCD converter.
package distance_filter_bcd_pkg;

  localparam int BIN_W      = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int ITER_W     = 4;   // counts the BIN_W double-dabble iterations
  localparam int STALE_W    = 32;  // wide enough for any practical timeout

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  // Number of clk cycles without a reading before the sensor is declared stale.
  // Never returns 0 so the saturating counter always has a reachable target.
  function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                 input int unsigned timeout_ms);
    int unsigned cyc;
    cyc = timeout_ms * (clk_freq / 1000);
    if (cyc == 0) cyc = 1;
    return cyc;
  endfunction

endpackage

// File: rtl/distance_filter_bcd_if.sv
// Measurement-in / filtered-result-out bundle between sensor front end,
// filter and display stage.
interface distance_filter_bcd_if;
  import distance_filter_bcd_pkg::*;

  logic [BIN_W-1:0] distance_in;
  logic             distance_in_valid;
  logic [BIN_W-1:0] avg_mm;
  logic [BCD_W-1:0] bcd;
  logic             bcd_valid;
  logic             busy;
  logic             out_of_range;
  logic             stale;

  // Producer of readings / consumer of results.
  modport master (
    output distance_in, distance_in_valid,
    input  avg_mm, bcd, bcd_valid, busy, out_of_range, stale
  );

  // The filter itself.
  modport slave (
    input  distance_in, distance_in_valid,
    output avg_mm, bcd, bcd_valid, busy, out_of_range, stale
  );
endinterface

// File: rtl/distance_filter_bcd_bin2bcd_seq.sv
// Iterative double-dabble: one bit per clock, LOAD -> 16 x SHIFT -> DONE.
module bin2bcd_seq
  import distance_filter_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BIN_W-1:0] o_bin,
  output logic [BCD_W-1:0] o_bcd
);

  conv_state_t r_state;
  conv_state_t w_state_next;

  logic [BIN_W-1:0]  r_shift;
  logic [BIN_W-1:0]  r_value;
  logic [BCD_W-1:0]  r_acc;
  logic [ITER_W-1:0] r_iter;
  logic [BIN_W-1:0]  r_bin_out;
  logic [BCD_W-1:0]  r_bcd_out;
  logic              r_done;

  logic              w_load;
  logic              w_shift;
  logic              w_finish;
  logic [BCD_W-1:0]  w_adj;

  // Add-3 correction for every digit that will overflow past 9 after the shift.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ? (r_acc[4*gi +: 4] + 4'd3)
                                                           : r_acc[4*gi +: 4];
    end
  endgenerate

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: start is only honoured when idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_iter == ITER_W'(BIN_W - 1)) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    w_load   = (r_state == ST_LOAD);
    w_shift  = (r_state == ST_SHIFT);
    w_finish = (r_state == ST_DONE);
    o_busy   = (r_state != ST_IDLE);
  end

  // Datapath: capture operand, shift {bcd, bin} left, publish result with a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_value   <= '0;
      r_acc     <= '0;
      r_iter    <= '0;
      r_bin_out <= '0;
      r_bcd_out <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift <= i_bin;
        r_value <= i_bin;
        r_acc   <= '0;
        r_iter  <= '0;
      end
      if (w_shift) begin
        r_acc   <= (w_adj << 1) | {{(BCD_W-1){1'b0}}, r_shift[BIN_W-1]};
        r_shift <= r_shift << 1;
        r_iter  <= r_iter + 1'b1;
      end
      if (w_finish) begin
        r_bin_out <= r_value;
        r_bcd_out <= r_acc;
        r_done    <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_bin  = r_bin_out;
  assign o_bcd  = r_bcd_out;

endmodule

// File: rtl/distance_filter_bcd.sv
// Range check, power-of-two moving average, stale detection, BCD output.
module distance_filter_bcd
  import distance_filter_bcd_pkg::*;
#(
  parameter int AVG_LOG2     = 2,
  parameter int MAX_VALID_MM = 4000,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int TIMEOUT_MS   = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  distance_filter_bcd_if.slave bus_if
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = BIN_W + AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [BIN_W-1:0]   MAX_MM   = BIN_W'(MAX_VALID_MM);
  localparam logic [STALE_W-1:0] TIMEOUT_CYC =
    STALE_W'(timeout_cycles(CLK_FREQ, TIMEOUT_MS));

  logic [BIN_W-1:0]   r_win [N];
  logic [SUM_W-1:0]   r_sum;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_full;
  logic               r_oor;
  logic [STALE_W-1:0] r_stale_cnt;
  logic               r_stale;

  logic               w_conv_busy;
  logic               w_conv_done;
  logic [BIN_W-1:0]   w_avg_out;
  logic [BCD_W-1:0]   w_bcd_out;
  logic               w_valid;
  logic               w_in_range;
  logic               w_check;
  logic               w_accept;
  logic               w_timeout;
  logic [BIN_W-1:0]   w_old;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic [SUM_W-1:0]   w_sample_ext;
  logic [BIN_W-1:0]   w_avg_in;

  assign w_valid      = bus_if.distance_in_valid;
  assign w_in_range   = (bus_if.distance_in != '0) && (bus_if.distance_in <= MAX_MM);
  // Readings arriving mid-conversion are ignored entirely (no range verdict).
  assign w_check      = w_valid && !w_conv_busy;
  assign w_accept     = w_check && w_in_range;
  assign w_old        = r_win[r_ptr];
  assign w_ptr_inc    = (AVG_LOG2 == 0) ? '0 : (r_ptr + 1'b1);
  assign w_sample_ext = SUM_W'(bus_if.distance_in);
  assign w_avg_in     = r_sum[AVG_LOG2 +: BIN_W];
  // Fires on the edge the idle counter reaches the limit; a reading on that edge wins.
  assign w_timeout    = !w_valid && (r_stale_cnt != TIMEOUT_CYC) &&
                        (r_stale_cnt + 1'b1 == TIMEOUT_CYC);

  // Window storage: prefill every slot when empty, otherwise overwrite the oldest.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        if (!r_full || (r_ptr == PTR_W'(k))) r_win[k] <= bus_if.distance_in;
      end
    end
  end

  // Running sum, write pointer and window-populated flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      if (!r_full) begin
        r_sum <= w_sample_ext << AVG_LOG2;
        r_ptr <= (AVG_LOG2 == 0) ? '0 : PTR_W'(1);
      end else begin
        r_sum <= r_sum - SUM_W'(w_old) + w_sample_ext;
        r_ptr <= w_ptr_inc;
      end
    end else if (w_timeout) begin
      r_full <= 1'b0;
    end
  end

  // Out-of-range flag reflects the last reading that was actually checked.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_oor <= 1'b0;
    else if (w_check) r_oor <= !w_in_range;
  end

  // Saturating idle counter; any reading (even a dropped one) restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stale_cnt <= '0;
      r_stale     <= 1'b0;
    end else if (w_valid) begin
      r_stale_cnt <= '0;
      r_stale     <= 1'b0;
    end else if (r_stale_cnt != TIMEOUT_CYC) begin
      r_stale_cnt <= r_stale_cnt + 1'b1;
      if (w_timeout) r_stale <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_bin   (w_avg_in),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bin   (w_avg_out),
    .o_bcd   (w_bcd_out)
  );

  assign bus_if.avg_mm       = w_avg_out;
  assign bus_if.bcd          = w_bcd_out;
  assign bus_if.bcd_valid    = w_conv_done;
  assign bus_if.busy         = w_conv_busy;
  assign bus_if.out_of_range = r_oor;
  assign bus_if.stale        = r_stale;

endmodule

// File: tb/tb_distance_filter_bcd.sv
// Self-checking bench: directed scenarios, then randomized readings against a
// queue-based moving-average model.
module tb_distance_filter_bcd;

  localparam int AVG_LOG2   = 2;
  localparam int N          = 1 << AVG_LOG2;
  localparam int MAX_MM     = 4000;
  localparam int CLK_FREQ   = 1_000_000;
  localparam int TIMEOUT_MS = 1;
  localparam longint TCYC   = longint'(TIMEOUT_MS) * (CLK_FREQ / 1000);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  distance_filter_bcd_if bus ();

  distance_filter_bcd #(
    .AVG_LOG2     (AVG_LOG2),
    .MAX_VALID_MM (MAX_MM),
    .CLK_FREQ     (CLK_FREQ),
    .TIMEOUT_MS   (TIMEOUT_MS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     pulses = 0;
  int     exp_pulses = 0;
  int     q[$];
  int     exp_next = 0;
  int     exp_shown = 0;
  bit     exp_oor = 1'b0;
  bit     last_acc = 1'b0;
  longint last_v = 0;
  longint next_ok = 0;
  longint acc_edge = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int v);
    logic [63:0] r;
    int div;
    r = '0;
    div = 1;
    for (int k = 0; k < 5; k++) begin
      r = r | (64'((v / div) % 10) << (4 * k));
      div = div * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.bcd_valid === 1'b1) pulses++;
  endtask

  // Spec-level model of what a reading on edge cyc does.
  task automatic model_valid(input int d);
    longint e;
    int s;
    e = cyc;
    if (e - last_v > TCYC) q.delete();
    last_v = e;
    last_acc = 1'b0;
    if (e >= next_ok) begin
      if (d == 0 || d > MAX_MM) begin
        exp_oor = 1'b1;
      end else begin
        exp_oor = 1'b0;
        last_acc = 1'b1;
        if (q.size() == 0) begin
          for (int k = 0; k < N; k++) q.push_back(d);
        end else begin
          void'(q.pop_front());
          q.push_back(d);
        end
        s = 0;
        foreach (q[k]) s += q[k];
        exp_next = s / N;
        acc_edge = e;
        next_ok = e + 19;
        exp_pulses++;
      end
    end
  endtask

  task automatic step(input bit v, input int d);
    bus.distance_in = 16'(d);
    bus.distance_in_valid = v;
    tick();
    bus.distance_in_valid = 1'b0;
    if (v) model_valid(d);
  endtask

  task automatic do_reset(input int n);
    if (next_ok > cyc + 1) exp_pulses--;
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    q.delete();
    exp_oor = 1'b0;
    exp_shown = 0;
    last_v = cyc;
    next_ok = 0;
    last_acc = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg"},   64'(bus.avg_mm), 64'd0);
    check({tag, "_bcd"},   64'(bus.bcd), 64'd0);
    check({tag, "_bv"},    64'(bus.bcd_valid), 64'd0);
    check({tag, "_busy"},  64'(bus.busy), 64'd0);
    check({tag, "_oor"},   64'(bus.out_of_range), 64'd0);
    check({tag, "_stale"}, 64'(bus.stale), 64'd0);
  endtask

  // Wait (bounded) for the result of the conversion started at acc_edge;
  // optionally drive a second reading inj_off edges after the accept.
  task automatic wait_done(input string tag, input int inj_off, input int inj_d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (inj_off > 0 && cyc + 1 == acc_edge + inj_off) step(1'b1, inj_d);
      else step(1'b0, 0);
      if (bus.bcd_valid === 1'b1) begin
        seen = 1'b1;
        check({tag, "_lat"},  64'(cyc), 64'(acc_edge + 18));
        check({tag, "_avg"},  64'(bus.avg_mm), 64'(exp_next));
        check({tag, "_bcd"},  64'(bus.bcd), to_bcd(exp_next));
        check({tag, "_busy0"}, 64'(bus.busy), 64'd0);
        exp_shown = exp_next;
      end else begin
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  initial begin
    int d;
    int gap;
    bus.distance_in = '0;
    bus.distance_in_valid = 1'b0;

    do_reset(3);
    check_zero("reset");

    // 1: first reading prefills the window
    step(1'b1, 1000);
    check("s1_busy_e0", 64'(bus.busy), 64'd1);
    check("s1_oor", 64'(bus.out_of_range), 64'd0);
    wait_done("s1", 0, 0);
    check("s1_avg_const", 64'(bus.avg_mm), 64'd1000);
    check("s1_bcd_const", 64'(bus.bcd), 64'h01000);

    // 2: back-to-back at the earliest accept edge
    step(1'b1, 1000); wait_done("s2a", 0, 0);
    step(1'b1, 1000); wait_done("s2b", 0, 0);
    step(1'b1, 2000); wait_done("s2c", 0, 0);
    check("s2_avg_const", 64'(bus.avg_mm), 64'd1250);
    check("s2_bcd_const", 64'(bus.bcd), 64'h01250);
    step(1'b1, 9999);
    check("s2_oor", 64'(bus.out_of_range), 64'd1);
    idle(25);
    check("s2_avg_hold", 64'(bus.avg_mm), 64'd1250);
    check("s2_pulses", 64'(pulses), 64'(exp_pulses));

    // 3: zero and just-over-limit rejected, window continues
    step(1'b1, 0);
    check("s3_oor0", 64'(bus.out_of_range), 64'd1);
    idle(3);
    step(1'b1, MAX_MM + 1);
    check("s3_oor4001", 64'(bus.out_of_range), 64'd1);
    idle(25);
    check("s3_pulses", 64'(pulses), 64'(exp_pulses));
    step(1'b1, 500);
    check("s3_oor_clr", 64'(bus.out_of_range), 64'd0);
    wait_done("s3", 0, 0);
    check("s3_avg_const", 64'(bus.avg_mm), 64'd1125);

    // 4: reading while busy is dropped
    do_reset(2);
    step(1'b1, 3000);
    wait_done("s4", 5, 100);
    check("s4_avg_const", 64'(bus.avg_mm), 64'd3000);
    idle(25);
    check("s4_pulses", 64'(pulses), 64'(exp_pulses));

    // 5: stale after TCYC idle edges, next reading prefills
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1000);
      wait_done("s5w", 0, 0);
    end
    while (cyc < last_v + TCYC - 1) step(1'b0, 0);
    check("s5_stale_pre", 64'(bus.stale), 64'd0);
    step(1'b0, 0);
    check("s5_stale", 64'(bus.stale), 64'd1);
    step(1'b1, 800);
    check("s5_stale_clr", 64'(bus.stale), 64'd0);
    wait_done("s5", 0, 0);
    check("s5_avg_const", 64'(bus.avg_mm), 64'd800);
    check("s5_bcd_const", 64'(bus.bcd), 64'h00800);

    // 6: reset in the middle of a conversion
    step(1'b1, 2222);
    idle(9);
    do_reset(1);
    check_zero("s6_rst");
    idle(25);
    check("s6_pulses", 64'(pulses), 64'(exp_pulses));
    step(1'b1, 1234);
    wait_done("s6", 0, 0);
    check("s6_avg_const", 64'(bus.avg_mm), 64'd1234);
    check("s6_bcd_const", 64'(bus.bcd), 64'h01234);

    // Randomized readings against the model
    for (int it = 0; it < 40; it++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(995, 1005))
                                        : int'($urandom_range(0, 4));
      idle(gap);
      check("rnd_stale_pre", 64'(bus.stale), 64'(cyc - last_v >= TCYC));
      if ($urandom_range(0, 4) == 0)
        d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_MM + 1, 65535));
      else
        d = int'($urandom_range(1, MAX_MM));
      step(1'b1, d);
      check("rnd_oor", 64'(bus.out_of_range), 64'(exp_oor));
      check("rnd_stale", 64'(bus.stale), 64'd0);
      check("rnd_busy", 64'(bus.busy), 64'(cyc < next_ok - 1));
      if (last_acc) begin
        if ($urandom_range(0, 1) == 0)
          wait_done("rnd", int'($urandom_range(1, 17)), int'($urandom_range(1, MAX_MM)));
        else
          wait_done("rnd", 0, 0);
      end else begin
        idle(2);
        check("rnd_avg_hold", 64'(bus.avg_mm), 64'(exp_shown));
      end
      check("rnd_pulses", 64'(pulses), 64'(exp_pulses));
    end

    idle(5);
    check("final_pulses", 64'(pulses), 64'(exp_pulses));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
